// File: rtl/seg7_multi_display_if.sv
// Handshake and display bundle for seg7_multi_display: value/mode in,
// segment pattern and status out.
interface seg7_multi_display_if #(
   parameter int DIGITS = 4,
   parameter int IN_W   = 14
);
   logic                  in_valid;
   logic                  in_ready;
   logic [IN_W-1:0]       in_value;
   logic                  mode_hex;
   logic                  lz_blank;
   logic                  blink_en;
   logic [7*DIGITS-1:0]   seg_out;
   logic                  overflow;
   logic                  upd;

   modport master (
      output in_valid, in_value, mode_hex, lz_blank, blink_en,
      input  in_ready, seg_out, overflow, upd
   );

   modport slave (
      input  in_valid, in_value, mode_hex, lz_blank, blink_en,
      output in_ready, seg_out, overflow, upd
   );
endinterface

// File: rtl/seg7_multi_display.sv
// Multi-digit active-low 7-segment controller: hex or decimal (double-dabble)
// rendering, leading-zero blanking, overflow dashes and whole-display blink.
module seg7_multi_display #(
   parameter int DIGITS    = 4,
   parameter int IN_W      = 14,
   parameter int BLINK_DIV = 25000000
) (
   input  logic                 clk,
   input  logic                 rst,
   seg7_multi_display_if.slave  bus
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SEG_W = 7 * DIGITS;
   localparam int CNT_W = $clog2(IN_W + 1);
   localparam int BLK_W = $clog2(BLINK_DIV);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

   function automatic logic [6:0] seg_code(input logic [3:0] nib);
      case (nib)
         4'h0: seg_code = 7'b1000000;
         4'h1: seg_code = 7'b1111001;
         4'h2: seg_code = 7'b0100100;
         4'h3: seg_code = 7'b0110000;
         4'h4: seg_code = 7'b0011001;
         4'h5: seg_code = 7'b0010010;
         4'h6: seg_code = 7'b0000010;
         4'h7: seg_code = 7'b1111000;
         4'h8: seg_code = 7'b0000000;
         4'h9: seg_code = 7'b0010000;
         4'hA: seg_code = 7'b0001000;
         4'hB: seg_code = 7'b0000011;
         4'hC: seg_code = 7'b0100111;
         4'hD: seg_code = 7'b0100001;
         4'hE: seg_code = 7'b0000110;
         default: seg_code = 7'b0001110;
      endcase
   endfunction

   state_t             state;
   logic [IN_W-1:0]    val_r;
   logic [BCD_W-1:0]   bcd_r;
   logic [CNT_W-1:0]   cnt;
   logic               hex_r;
   logic               lzb_r;
   logic               ovf_acc;
   logic [SEG_W-1:0]   disp_r;
   logic               overflow_r;
   logic               upd_r;
   logic [BLK_W-1:0]   blink_cnt;
   logic               phase;

   logic [BCD_W-1:0]       bcd_adj;
   logic [BCD_W+IN_W-1:0]  val_ext;
   logic [BCD_W-1:0]       nibs;
   logic                   ovf_next;
   logic [SEG_W-1:0]       disp_next;
   logic                   seen;
   logic [3:0]             nib;

   // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
   always_comb begin
      bcd_adj = bcd_r;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_r[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
      end
   end

   // Hex digits come straight from the captured value; bits above the display overflow.
   assign val_ext = {{BCD_W{1'b0}}, val_r};

   always_comb begin
      nibs      = hex_r ? val_ext[BCD_W-1:0] : bcd_r;
      ovf_next  = hex_r ? (|val_ext[BCD_W +: IN_W]) : ovf_acc;
      disp_next = '1;
      seen      = 1'b0;
      nib       = 4'h0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nib = nibs[4*i +: 4];
         if (nib != 4'h0)
            seen = 1'b1;
         if (ovf_next)
            disp_next[7*i +: 7] = SEG_DASH;
         else if (lzb_r && !seen && (i != 0))
            disp_next[7*i +: 7] = SEG_BLANK;
         else
            disp_next[7*i +: 7] = seg_code(nib);
      end
   end

   // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         val_r      <= '0;
         bcd_r      <= '0;
         cnt        <= '0;
         hex_r      <= 1'b0;
         lzb_r      <= 1'b0;
         ovf_acc    <= 1'b0;
         disp_r     <= '1;
         overflow_r <= 1'b0;
         upd_r      <= 1'b0;
      end else begin
         upd_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  val_r   <= bus.in_value;
                  hex_r   <= bus.mode_hex;
                  lzb_r   <= bus.lz_blank;
                  bcd_r   <= '0;
                  cnt     <= '0;
                  ovf_acc <= 1'b0;
                  state   <= bus.mode_hex ? S_DONE : S_CONV;
               end
            end
            S_CONV: begin
               // Shift {bcd_adj, val_r} left; a 1 leaving the BCD top means the value needs more digits.
               bcd_r   <= {bcd_adj[BCD_W-2:0], val_r[IN_W-1]};
               val_r   <= val_r << 1;
               ovf_acc <= ovf_acc | bcd_adj[BCD_W-1];
               cnt     <= cnt + 1'b1;
               if (cnt == CNT_W'(IN_W - 1))
                  state <= S_DONE;
            end
            S_DONE: begin
               disp_r     <= disp_next;
               overflow_r <= ovf_next;
               upd_r      <= 1'b1;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   assign bus.in_ready = (state == S_IDLE);
   assign bus.seg_out  = (bus.blink_en && phase) ? {SEG_W{1'b1}} : disp_r;
   assign bus.overflow = overflow_r;
   assign bus.upd      = upd_r;

endmodule

// File: tb/tb_seg7_multi_display.sv
// Directed bench for seg7_multi_display: vector table of hex/decimal renders
// plus hand-written blink and mid-conversion reset sequences.
module tb_seg7_multi_display;

   localparam int DIGITS    = 4;
   localparam int IN_W      = 14;
   localparam int BLINK_DIV = 4;

   localparam logic [6:0] C0 = 7'b1000000, C1 = 7'b1111001, C2 = 7'b0100100,
                          C3 = 7'b0110000, C4 = 7'b0011001, C5 = 7'b0010010,
                          C7 = 7'b1111000, C9 = 7'b0010000, CA = 7'b0001000,
                          CF = 7'b0001110, BL = 7'b1111111, DA = 7'b0111111;

   localparam logic [27:0] D1234 = {C1, C2, C3, C4};

   typedef struct {
      logic [13:0] value;
      logic        hex;
      logic        lzb;
      logic [27:0] seg;
      logic        ovf;
      int          lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   n_edges;

   seg7_multi_display_if #(.DIGITS(DIGITS), .IN_W(IN_W)) bus ();

   seg7_multi_display #(.DIGITS(DIGITS), .IN_W(IN_W), .BLINK_DIV(BLINK_DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Edges since reset release; blink phase is bit 2 of this count when BLINK_DIV = 4.
   always @(posedge clk or posedge rst) begin
      if (rst) n_edges <= 0;
      else     n_edges <= n_edges + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [13:0] v, input logic h, input logic z,
                       output int lat, output int busy);
      int w;
      w = 0;
      while (!bus.in_ready && w < 50) begin
         tick();
         w++;
      end
      if (!bus.in_ready) check("ready_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_value = v;
      bus.mode_hex = h;
      bus.lz_blank = z;
      tick();
      bus.in_valid = 1'b0;
      lat  = 0;
      busy = 0;
      while (!bus.upd && lat < 100) begin
         if (!bus.in_ready) busy++;
         tick();
         lat++;
      end
   endtask

   vec_t vecs[11];
   int   lat, busy, upd_seen, w;
   logic [27:0] exp_seg;

   initial begin
      vecs[0]  = '{14'h1A2F,    1'b1, 1'b0, {C1, CA, C2, CF}, 1'b0, 1};
      vecs[1]  = '{14'd1234,    1'b0, 1'b0, D1234,            1'b0, 15};
      vecs[2]  = '{14'd7,       1'b0, 1'b1, {BL, BL, BL, C7}, 1'b0, 15};
      vecs[3]  = '{14'd0,       1'b0, 1'b1, {BL, BL, BL, C0}, 1'b0, 15};
      vecs[4]  = '{14'd10000,   1'b0, 1'b0, {DA, DA, DA, DA}, 1'b1, 15};
      vecs[5]  = '{14'd9999,    1'b0, 1'b0, {C9, C9, C9, C9}, 1'b0, 15};
      vecs[6]  = '{14'h3FFF,    1'b1, 1'b0, {C3, CF, CF, CF}, 1'b0, 1};
      vecs[7]  = '{14'h0005,    1'b1, 1'b1, {BL, BL, BL, C5}, 1'b0, 1};
      vecs[8]  = '{14'h3FFF,    1'b0, 1'b1, {DA, DA, DA, DA}, 1'b1, 15};
      vecs[9]  = '{14'd305,     1'b0, 1'b1, {BL, C3, C0, C5}, 1'b0, 15};
      vecs[10] = '{14'h0000,    1'b1, 1'b1, {BL, BL, BL, C0}, 1'b0, 1};

      bus.in_valid = 1'b0;
      bus.in_value = '0;
      bus.mode_hex = 1'b0;
      bus.lz_blank = 1'b0;
      bus.blink_en = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;

      check("reset_seg",      32'(bus.seg_out),  32'h0FFFFFFF);
      check("reset_overflow", 32'(bus.overflow), 32'd0);
      check("reset_upd",      32'(bus.upd),      32'd0);
      check("reset_ready",    32'(bus.in_ready), 32'd1);

      for (int i = 0; i < 11; i++) begin
         send(vecs[i].value, vecs[i].hex, vecs[i].lzb, lat, busy);
         check($sformatf("v%0d_latency", i),  32'(lat),          32'(vecs[i].lat));
         check($sformatf("v%0d_busy", i),     32'(busy),         32'(vecs[i].lat));
         check($sformatf("v%0d_seg", i),      32'(bus.seg_out),  32'(vecs[i].seg));
         check($sformatf("v%0d_overflow", i), 32'(bus.overflow), 32'(vecs[i].ovf));
         tick();
         check($sformatf("v%0d_upd_pulse", i), 32'(bus.upd),     32'd0);
      end

      // Blink over a 1234 display: blank while the free-running phase is 1.
      send(14'd1234, 1'b0, 1'b0, lat, busy);
      check("blink_base_seg", 32'(bus.seg_out), 32'(D1234));
      bus.blink_en = 1'b1;
      #1;
      for (int c = 0; c < 16; c++) begin
         exp_seg = (((n_edges >> 2) & 1) != 0) ? 28'hFFFFFFF : D1234;
         check($sformatf("blink_c%0d", c), 32'(bus.seg_out), 32'(exp_seg));
         tick();
      end
      w = 0;
      while ((((n_edges >> 2) & 1) == 0) && w < 10) begin
         tick();
         w++;
      end
      check("blink_phase1_blank", 32'(bus.seg_out), 32'h0FFFFFFF);
      bus.blink_en = 1'b0;
      #1;
      check("blink_off_restore", 32'(bus.seg_out), 32'(D1234));

      // Reset five cycles into a decimal conversion.
      bus.in_valid = 1'b1;
      bus.in_value = 14'd4321;
      bus.mode_hex = 1'b0;
      bus.lz_blank = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      check("midconv_busy", 32'(bus.in_ready), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_seg",      32'(bus.seg_out),  32'h0FFFFFFF);
      check("async_rst_overflow", 32'(bus.overflow), 32'd0);
      check("async_rst_ready",    32'(bus.in_ready), 32'd1);
      tick();
      rst = 1'b0;
      upd_seen = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.upd) upd_seen++;
         tick();
      end
      check("no_upd_after_rst", 32'(upd_seen), 32'd0);
      check("seg_still_blank",  32'(bus.seg_out), 32'h0FFFFFFF);

      send(14'h0003, 1'b1, 1'b0, lat, busy);
      check("post_rst_latency",  32'(lat),          32'd1);
      check("post_rst_seg",      32'(bus.seg_out),  32'({C0, C0, C0, C3}));
      check("post_rst_overflow", 32'(bus.overflow), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
